// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: buffers FP operation requests in a small FIFO, issues them one
// at a time to a fixed-latency double-precision FPU and returns an in-order
// writeback with its own valid/ready handshake. Illegal opcodes and FPU faults
// come back as writebacks flagged wb_illegal with zero data.
module fpu_issue_ctrl #(
    parameter int FPU_LAT = 1,
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_rs1,
    input  logic [63:0]      req_rs2,
    input  logic [2:0]       req_funct3,
    input  logic [TAG_W-1:0] req_rd,
    output logic [63:0]      fpu_rs1,
    output logic [63:0]      fpu_rs2,
    output logic [2:0]       fpu_funct3,
    input  logic [63:0]      fpu_result,
    input  logic             fpu_valid,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [63:0]      wb_data,
    output logic [TAG_W-1:0] wb_rd,
    output logic             wb_illegal,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [63:0]      rs1;
        logic [63:0]      rs2;
        logic [2:0]       funct3;
        logic [TAG_W-1:0] rd;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    entry_t           head;

    // A full FIFO refuses pushes even when it is popping in the same cycle,
    // so req_ready never depends on the FSM.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || !empty;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rs1: req_rs1, rs2: req_rs2, funct3: req_funct3, rd: req_rd};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Issue/writeback FSM with registered FPU operands and writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            fpu_rs1    <= '0;
            fpu_rs2    <= '0;
            fpu_funct3 <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_rd      <= '0;
            wb_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        wb_rd <= head.rd;
                        if (head.funct3[2]) begin
                            wb_illegal <= 1'b1;
                            wb_data    <= '0;
                            wb_valid   <= 1'b1;
                            state      <= RESP;
                        end else begin
                            fpu_rs1    <= head.rs1;
                            fpu_rs2    <= head.rs2;
                            fpu_funct3 <= head.funct3;
                            lat_cnt    <= '0;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (lat_cnt == LAT_W'(FPU_LAT - 1)) begin
                        if (fpu_valid) begin
                            wb_data    <= fpu_result;
                            wb_illegal <= 1'b0;
                        end else begin
                            wb_data    <= '0;
                            wb_illegal <= 1'b1;
                        end
                        wb_valid <= 1'b1;
                        state    <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed bench for fpu_issue_ctrl. Four instances with
// different FPU latencies share one clock; each has an FPU stub returning
// rs1 XOR rs2 with a controllable completion flag.
module tb_fpu_issue_ctrl;

    localparam int NI = 4;
    localparam int LAT_TAB [NI] = '{1, 3, 4, 2};

    logic        clk = 1'b0;
    logic        rst        [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic [63:0] req_rs1    [NI];
    logic [63:0] req_rs2    [NI];
    logic [2:0]  req_funct3 [NI];
    logic [4:0]  req_rd     [NI];
    logic [63:0] fpu_rs1    [NI];
    logic [63:0] fpu_rs2    [NI];
    logic [2:0]  fpu_funct3 [NI];
    logic [63:0] fpu_result [NI];
    logic        fpu_valid  [NI];
    logic        stub_valid [NI];
    logic        wb_valid   [NI];
    logic        wb_ready   [NI];
    logic [63:0] wb_data    [NI];
    logic [4:0]  wb_rd      [NI];
    logic        wb_illegal [NI];
    logic        busy       [NI];

    int checks   = 0;
    int failures = 0;

    // Free-running clock shared by all instances.
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign fpu_result[g] = fpu_rs1[g] ^ fpu_rs2[g];
        assign fpu_valid[g]  = stub_valid[g];

        fpu_issue_ctrl #(.FPU_LAT(LAT_TAB[g]), .TAG_W(5), .DEPTH(2)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_rs1    (req_rs1[g]),
            .req_rs2    (req_rs2[g]),
            .req_funct3 (req_funct3[g]),
            .req_rd     (req_rd[g]),
            .fpu_rs1    (fpu_rs1[g]),
            .fpu_rs2    (fpu_rs2[g]),
            .fpu_funct3 (fpu_funct3[g]),
            .fpu_result (fpu_result[g]),
            .fpu_valid  (fpu_valid[g]),
            .wb_valid   (wb_valid[g]),
            .wb_ready   (wb_ready[g]),
            .wb_data    (wb_data[g]),
            .wb_rd      (wb_rd[g]),
            .wb_illegal (wb_illegal[g]),
            .busy       (busy[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; all driving and sampling happens there.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic [63:0] rs1, input logic [63:0] rs2,
                                 input logic [2:0] f3, input logic [4:0] rd);
        req_rs1[i]    = rs1;
        req_rs2[i]    = rs2;
        req_funct3[i] = f3;
        req_rd[i]     = rd;
        req_valid[i]  = 1'b1;
    endtask

    // Push one request, wait for its writeback, check latency and payload, then hand it off.
    task automatic runOp(input int i, input string tag, input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [2:0] f3, input logic [4:0] rd, input int exp_lat,
                         input logic [63:0] exp_data, input logic exp_ill);
        int n;
        applyStimulus(i, rs1, rs2, f3, rd);
        n = 0;
        while (!req_ready[i] && n < 40) begin
            cycle();
            n++;
        end
        cycle();
        req_valid[i] = 1'b0;
        n = 0;
        while (!wb_valid[i] && n < 40) begin
            cycle();
            n++;
        end
        checkOutput({tag, " latency"}, 64'(n), 64'(exp_lat));
        checkOutput({tag, " wb_data"}, wb_data[i], exp_data);
        checkOutput({tag, " wb_rd"}, 64'(wb_rd[i]), 64'(rd));
        checkOutput({tag, " wb_illegal"}, 64'(wb_illegal[i]), 64'(exp_ill));
        wb_ready[i] = 1'b1;
        cycle();
        wb_ready[i] = 1'b0;
        checkOutput({tag, " wb_valid dropped"}, 64'(wb_valid[i]), 64'd0);
    endtask

    initial begin
        int got;
        int last;
        int nrd;
        bit acc;

        for (int i = 0; i < NI; i++) begin
            rst[i]        = 1'b1;
            req_valid[i]  = 1'b0;
            req_rs1[i]    = '0;
            req_rs2[i]    = '0;
            req_funct3[i] = '0;
            req_rd[i]     = '0;
            wb_ready[i]   = 1'b0;
            stub_valid[i] = 1'b1;
        end
        cycle();
        cycle();
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;

        checkOutput("reset wb_valid", 64'(wb_valid[0]), 64'd0);
        checkOutput("reset req_ready", 64'(req_ready[0]), 64'd1);
        checkOutput("reset busy", 64'(busy[0]), 64'd0);
        checkOutput("reset fpu_rs1", fpu_rs1[0], 64'd0);

        // Test 1: single FMUL, latency FPU_LAT+1 = 2.
        runOp(0, "t1", 64'h3FF0000000000000, 64'h4000000000000000, 3'b010, 5'd5,
              2, 64'h7FF0000000000000, 1'b0);
        checkOutput("t1 busy after handshake", 64'(busy[0]), 64'd0);
        checkOutput("t1 fpu_rs1", fpu_rs1[0], 64'h3FF0000000000000);
        checkOutput("t1 fpu_rs2", fpu_rs2[0], 64'h4000000000000000);
        checkOutput("t1 fpu_funct3", 64'(fpu_funct3[0]), 64'd2);

        // Test 2: illegal funct3, latency 1, FPU operands untouched.
        runOp(0, "t2", 64'h1234, 64'h5678, 3'b101, 5'd7, 1, 64'd0, 1'b1);
        checkOutput("t2 fpu_rs1 kept", fpu_rs1[0], 64'h3FF0000000000000);
        checkOutput("t2 fpu_funct3 kept", 64'(fpu_funct3[0]), 64'd2);

        // Test 3: stalled writeback fills FIFO after DEPTH+1 accepts, then drains in order.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 64'h1000 + 64'(k), 64'h10, 3'b000, 5'(k));
            checkOutput("t3 ready before accept", 64'(req_ready[0]), 64'd1);
            cycle();
        end
        applyStimulus(0, 64'h1004, 64'h10, 3'b000, 5'd4);
        checkOutput("t3 ready after 3 accepts", 64'(req_ready[0]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t3 stall wb_valid", 64'(wb_valid[0]), 64'd1);
            checkOutput("t3 stall wb_rd", 64'(wb_rd[0]), 64'd1);
            checkOutput("t3 stall wb_data", wb_data[0], 64'h1011);
            checkOutput("t3 stall ready", 64'(req_ready[0]), 64'd0);
            cycle();
        end
        wb_ready[0] = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            if (wb_valid[0]) begin
                checkOutput("t3 order wb_rd", 64'(wb_rd[0]), 64'(got + 1));
                checkOutput("t3 order wb_data", wb_data[0], (64'h1000 + 64'(got + 1)) ^ 64'h10);
                got++;
            end
            acc = req_valid[0] && req_ready[0];
            cycle();
            if (acc) req_valid[0] = 1'b0;
        end
        checkOutput("t3 writeback count", 64'(got), 64'd4);
        req_valid[0] = 1'b0;
        wb_ready[0]  = 1'b0;

        // Test 4: FPU reports no completion at the sample edge -> fault.
        stub_valid[1] = 1'b0;
        runOp(1, "t4", 64'hAAAA, 64'h5555, 3'b011, 5'd9, 4, 64'd0, 1'b1);
        stub_valid[1] = 1'b1;

        // Test 5: reset in the middle of EXEC discards the op.
        applyStimulus(2, 64'hF0F0, 64'h0F0F, 3'b000, 5'd3);
        cycle();
        req_valid[2] = 1'b0;
        cycle();
        cycle();
        cycle();
        rst[2] = 1'b1;
        cycle();
        rst[2] = 1'b0;
        checkOutput("t5 wb_valid", 64'(wb_valid[2]), 64'd0);
        checkOutput("t5 wb_data", wb_data[2], 64'd0);
        checkOutput("t5 wb_rd", 64'(wb_rd[2]), 64'd0);
        checkOutput("t5 wb_illegal", 64'(wb_illegal[2]), 64'd0);
        checkOutput("t5 fpu_rs1", fpu_rs1[2], 64'd0);
        checkOutput("t5 fpu_rs2", fpu_rs2[2], 64'd0);
        checkOutput("t5 fpu_funct3", 64'(fpu_funct3[2]), 64'd0);
        checkOutput("t5 busy", 64'(busy[2]), 64'd0);
        checkOutput("t5 req_ready", 64'(req_ready[2]), 64'd1);
        wb_ready[2] = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            if (wb_valid[2]) got++;
            cycle();
        end
        wb_ready[2] = 1'b0;
        checkOutput("t5 no ghost writeback", 64'(got), 64'd0);
        runOp(2, "t5 after", 64'h00FF, 64'hFF00, 3'b001, 5'd11, 5, 64'hFFFF, 1'b0);

        // Test 6: continuous traffic, one writeback every FPU_LAT+2 = 4 cycles.
        wb_ready[3] = 1'b1;
        nrd = 1;
        applyStimulus(3, 64'hA0 + 64'(nrd), 64'h5, 3'b000, 5'(nrd));
        got  = 0;
        last = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            if (wb_valid[3]) begin
                checkOutput("t6 wb_rd", 64'(wb_rd[3]), 64'(got + 1));
                checkOutput("t6 wb_data", wb_data[3], (64'hA0 + 64'(got + 1)) ^ 64'h5);
                checkOutput("t6 wb_illegal", 64'(wb_illegal[3]), 64'd0);
                if (got > 0) checkOutput("t6 spacing", 64'(c - last), 64'd4);
                last = c;
                got++;
            end
            acc = req_valid[3] && req_ready[3];
            cycle();
            if (acc) begin
                nrd++;
                applyStimulus(3, 64'hA0 + 64'(nrd), 64'h5, 3'b000, 5'(nrd));
            end
        end
        checkOutput("t6 writeback count", 64'(got), 64'd5);
        req_valid[3] = 1'b0;
        wb_ready[3]  = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
